cipher_msg_sequencer: RTL
=========================

Name: cipher_msg_sequencer

Overview:
- Sequential front-end for the combinational encryptor/decryptor pair.
- Accepts a byte stream over valid/ready and buffers MSG_LEN characters.
- In encrypt mode, folds lowercase to uppercase and records a per-byte case flag; in decrypt mode, restores case from the supplied flags.
- Presents the buffered message to the engine as a flat bus, waits a fixed engine latency, captures the result and streams it out with backpressure.

Parameters:
MSG_LEN, 5, characters per message (>=1)
SEC_LEN, 7, secret length; passed through unchanged to the engine instances and not used internally
ENGINE_LAT, 2, cycles from stable eng_in to eng_out capture (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a message; honoured only in IDLE
mode  in  1  0=encrypt, 1=decrypt; sampled with start
s_valid  in  1  input byte valid
s_ready  out  1  input byte accepted when s_valid&&s_ready
s_data  in  8  input character
s_lc  in  1  decrypt mode only: 1 = restore this byte to lowercase
eng_sel  out  1  latched mode, drives encryptor/decryptor select
eng_in  out  8*MSG_LEN  buffered message; byte i at [8i+7:8i]
eng_out  in  8*MSG_LEN  engine result, same packing
m_valid  out  1  output byte valid
m_ready  in  1  downstream accepts byte
m_data  out  8  output character
m_lc  out  1  encrypt mode: case flag of this byte; always 0 in decrypt mode
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last output byte is accepted

Behaviour:
- Reset (async assert, synchronous deassert use) values:
  - state=IDLE; s_ready, m_valid, busy, done, m_lc = 0.
  - m_data, eng_in, eng_sel, buffers, flags, counters = 0.
- States: IDLE -> LOAD -> WAIT -> DRAIN -> IDLE.
- IDLE:
  - start=1 latches mode into eng_sel, clears the index, and goes to LOAD next cycle.
  - start in any other state is ignored.
- LOAD:
  - s_ready=1. Each accepted byte is written to buffer[idx], then idx increments.
  - Encrypt: if s_data is in 'a'..'z', store s_data-32 and flag=1; otherwise store s_data unchanged and flag=0.
  - Decrypt: store s_data unchanged; flag=s_lc.
  - On acceptance of byte MSG_LEN-1: s_ready drops the next cycle, the wait counter loads ENGINE_LAT-1, and the state goes to WAIT.
- WAIT:
  - eng_in is stable from buffer and is never modified while in WAIT or DRAIN.
  - Counter decrements each cycle. When it reaches 0, capture eng_out into the result buffer, reset idx, and go to DRAIN.
  - Total WAIT duration is exactly ENGINE_LAT cycles.
- DRAIN:
  - m_valid=1; m_data=result[idx].
  - Encrypt: m_lc=flag[idx].
  - Decrypt: m_data = result[idx]+32 iff flag[idx]=1 and result[idx] is in 'A'..'Z'; otherwise result[idx] unchanged. m_lc=0.
  - m_data and m_lc hold stable while m_valid&&!m_ready.
  - On m_valid&&m_ready, idx increments.
  - On acceptance of the last byte: m_valid=0, done=1 for one cycle, and the state returns to IDLE.
- Latency: the first m_valid occurs ENGINE_LAT+1 cycles after the last input handshake.
- Throughput: one byte per cycle in each direction when not stalled.
- Index arithmetic: width clog2(MSG_LEN)+1; no wrap past MSG_LEN-1.
- MSG_LEN=1: LOAD accepts one byte, then goes directly to WAIT.
- s_valid while s_ready=0: ignored; no data is lost or consumed.
- start while start=1 and busy: ignored, with no effect on the current message.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; any partial message is discarded.
- Non-letter bytes are never case-modified in either mode.

Test Plan:
- Encrypt "HeLlo", identity engine stub, ENGINE_LAT=2, m_ready=1 -> eng_in bytes "HELLO"; output "HELLO" with m_lc=0,1,0,1,1; first m_valid 3 cycles after the 5th s handshake; done pulses once.
- Decrypt "HELLO" with s_lc=0,1,0,1,1, identity stub -> output "HeLlo", m_lc all 0; eng_sel=1 throughout.
- Decrypt "A3Z{!" with s_lc=1,1,1,1,1 -> output "a3z{!"; only letters are shifted.
- Backpressure: during DRAIN, hold m_ready=0 for 4 cycles on byte 2 -> m_data/m_lc stable for those cycles; byte order preserved; all 5 bytes delivered.
- Gapped input: s_valid toggled 1,0,1,0,... -> s_ready stays 1 in LOAD; exactly 5 bytes stored; a start pulse issued during LOAD is ignored.
- Assert rst_n=0 after 3 bytes in LOAD -> s_ready, m_valid, busy = 0 immediately. A new start plus "Hello" then produces a correct, complete message.

Source files
------------

// File: rtl/cipher_msg_sequencer.sv
// Sequential front-end for the combinational cipher engine: buffers a message,
// case-folds it, waits the engine latency, then streams the result out.
module cipher_msg_sequencer #(
    parameter int unsigned MSG_LEN    = 5,
    parameter int unsigned SEC_LEN    = 7,
    parameter int unsigned ENGINE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [7:0]           s_data,
    input  logic                 s_lc,
    output logic                 eng_sel,
    output logic [8*MSG_LEN-1:0] eng_in,
    input  logic [8*MSG_LEN-1:0] eng_out,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [7:0]           m_data,
    output logic                 m_lc,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned   IW       = $clog2(MSG_LEN) + 1;
    localparam int unsigned   CW       = $clog2(ENGINE_LAT) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(MSG_LEN - 1);

    if (MSG_LEN < 1 || ENGINE_LAT < 1 || SEC_LEN < 1) begin : g_param_check
        $error("cipher_msg_sequencer: MSG_LEN, ENGINE_LAT and SEC_LEN must be >= 1");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_DRAIN} state_e;

    state_e                  state_q;
    logic [MSG_LEN-1:0][7:0] msg_q;
    logic [MSG_LEN-1:0][7:0] res_q;
    logic [MSG_LEN-1:0]      flag_q;
    logic [IW-1:0]           idx_q;
    logic [IW-1:0]           idx_d;
    logic [CW-1:0]           cnt_q;
    logic                    eng_sel_q;
    logic                    s_ready_q;
    logic                    m_valid_q;
    logic                    m_lc_q;
    logic                    busy_q;
    logic                    done_q;
    logic [7:0]              m_data_q;
    logic [7:0]              in_byte_d;
    logic                    in_flag_d;
    logic [7:0]              nxt_raw_d;
    logic                    nxt_flag_d;

    // Returns {m_lc, m_data} for one engine result byte.
    function automatic logic [8:0] present(input logic [7:0] raw, input logic fl,
                                           input logic dec);
        logic [8:0] r;
        r = {fl, raw};
        if (dec) begin
            r[8] = 1'b0;
            if (fl && raw >= 8'h41 && raw <= 8'h5A) r[7:0] = raw + 8'd32;
        end
        return r;
    endfunction

    always_comb begin
        in_byte_d = s_data;
        in_flag_d = s_lc;
        if (!eng_sel_q) begin
            in_flag_d = (s_data >= 8'h61 && s_data <= 8'h7A);
            if (in_flag_d) in_byte_d = s_data - 8'd32;
        end
        idx_d      = idx_q + IW'(1);
        nxt_raw_d  = '0;
        nxt_flag_d = 1'b0;
        for (int unsigned i = 0; i < MSG_LEN; i++) begin
            if (idx_d == IW'(i)) begin
                nxt_raw_d  = res_q[i];
                nxt_flag_d = flag_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            msg_q     <= '0;
            res_q     <= '0;
            flag_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            eng_sel_q <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_lc_q    <= 1'b0;
            m_data_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        eng_sel_q <= mode;
                        idx_q     <= '0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (s_valid && s_ready_q) begin
                        for (int unsigned i = 0; i < MSG_LEN; i++) begin
                            if (idx_q == IW'(i)) begin
                                msg_q[i]  <= in_byte_d;
                                flag_q[i] <= in_flag_d;
                            end
                        end
                        if (idx_q == LAST_IDX) begin
                            s_ready_q <= 1'b0;
                            cnt_q     <= CW'(ENGINE_LAT - 1);
                            state_q   <= ST_WAIT;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                end
                ST_WAIT: begin
                    // Capture and present byte 0 on the same edge so m_valid
                    // rises ENGINE_LAT+1 cycles after the last input handshake.
                    if (cnt_q == '0) begin
                        res_q              <= eng_out;
                        idx_q              <= '0;
                        m_valid_q          <= 1'b1;
                        {m_lc_q, m_data_q} <= present(eng_out[7:0], flag_q[0], eng_sel_q);
                        state_q            <= ST_DRAIN;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (m_ready) begin
                        if (idx_q == LAST_IDX) begin
                            m_valid_q <= 1'b0;
                            m_lc_q    <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            idx_q              <= idx_d;
                            {m_lc_q, m_data_q} <= present(nxt_raw_d, nxt_flag_d, eng_sel_q);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign eng_in  = msg_q;
    assign eng_sel = eng_sel_q;
    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_lc    = m_lc_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
